// File: rtl/raster_coord_gen.sv
// Raster (x, y) coordinate source with ready/valid output and run-time frame geometry.
// Optional RASTER_COORD_GEN_PIX_INDEX_EN adds a linear pixel index output.
module raster_coord_gen #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 12
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         cfg_continuous,
    input  logic [CNT_WIDTH-1:0]         cfg_width,
    input  logic [CNT_WIDTH-1:0]         cfg_height,
    input  logic signed [DATA_WIDTH-1:0] cfg_x0,
    input  logic signed [DATA_WIDTH-1:0] cfg_y0,
    input  logic signed [DATA_WIDTH-1:0] cfg_dx,
    input  logic signed [DATA_WIDTH-1:0] cfg_dy,
    input  logic                         m_ready,
    output logic                         m_valid,
    output logic signed [DATA_WIDTH-1:0] x,
    output logic signed [DATA_WIDTH-1:0] y,
    output logic                         sof,
    output logic                         eol,
    output logic                         eof,
    output logic                         busy,
`ifdef RASTER_COORD_GEN_PIX_INDEX_EN
    output logic [2*CNT_WIDTH-1:0]       pix_idx,
`endif
    output logic                         frame_done
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state, state_nxt;

    logic [CNT_WIDTH-1:0]         width_s;
    logic [CNT_WIDTH-1:0]         height_s;
    logic signed [DATA_WIDTH-1:0] x0_s;
    logic signed [DATA_WIDTH-1:0] dx_s;
    logic signed [DATA_WIDTH-1:0] dy_s;
    logic [CNT_WIDTH-1:0]         col;
    logic [CNT_WIDTH-1:0]         row;
    logic signed [DATA_WIDTH-1:0] x_r;
    logic signed [DATA_WIDTH-1:0] y_r;
    logic                         done_r;

    logic run;
    logic xfer;
    logic last_col;
    logic last_row;
    logic latch;
    logic finish;

    assign run      = (state == RUN);
    assign xfer     = run && m_ready;
    assign last_col = (col == width_s);
    assign last_row = (row == height_s);

    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        finish    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    latch     = 1'b1;
                end
            end
            RUN: begin
                // abort wins over a same-cycle transfer
                if (abort) begin
                    state_nxt = IDLE;
                    finish    = 1'b1;
                end else if (xfer && last_col && last_row) begin
                    finish = 1'b1;
                    if (cfg_continuous) begin
                        latch = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            width_s  <= '0;
            height_s <= '0;
            x0_s     <= '0;
            dx_s     <= '0;
            dy_s     <= '0;
            col      <= '0;
            row      <= '0;
            x_r      <= '0;
            y_r      <= '0;
            done_r   <= 1'b0;
        end else begin
            done_r <= finish;
            if (latch) begin
                width_s  <= cfg_width;
                height_s <= cfg_height;
                x0_s     <= cfg_x0;
                dx_s     <= cfg_dx;
                dy_s     <= cfg_dy;
                col      <= '0;
                row      <= '0;
                x_r      <= cfg_x0;
                y_r      <= cfg_y0;
            end else if (xfer && !abort) begin
                if (!last_col) begin
                    col <= col + 1'b1;
                    x_r <= x_r + dx_s;
                end else if (!last_row) begin
                    col <= '0;
                    row <= row + 1'b1;
                    x_r <= x0_s;
                    y_r <= y_r + dy_s;
                end
            end
        end
    end

`ifdef RASTER_COORD_GEN_PIX_INDEX_EN
    logic [2*CNT_WIDTH-1:0] pix_r;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pix_r <= '0;
        end else if (latch) begin
            pix_r <= '0;
        end else if (xfer && !abort && !(last_col && last_row)) begin
            pix_r <= pix_r + 1'b1;
        end
    end

    assign pix_idx = pix_r;
`endif

    assign m_valid    = run;
    assign busy       = run;
    assign x          = x_r;
    assign y          = y_r;
    assign sof        = run && (col == '0) && (row == '0);
    assign eol        = run && last_col;
    assign eof        = run && last_col && last_row;
    assign frame_done = done_r;

endmodule
